// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RISC-V immediate decode stage with two-entry skid buffer
//
// Purpose: decodes one instruction per accepted handshake into an XLEN-wide
// immediate, a format code and an illegal flag, one cycle after accept.
// A sideband tag travels with each instruction unchanged.
//
// Optional feature macro: IMM_ZICSR_EN (decode CSR immediate forms of SYSTEM).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drops both held entries and any offered instruction
//   in_valid/ready  input handshake; in_ready is a register (== !skid_full)
//   in_inst, in_tag instruction word and sideband tag
//   out_valid/ready output handshake
//   out_imm         decoded immediate (XLEN bits)
//   out_fmt         0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 Z
//   out_illegal     unsupported opcode or shift encoding
//   out_tag         tag of the instruction on the output
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every legal opcode ends in 2'b11, so compressed/invalid low bits fall
  // through to the default (illegal) arm.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b1100111, 7'b0000011: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_inst[31:20]));
      end
      7'b0010011: begin
        if (is_shift) begin
          dec_fmt = FMT_SH;
          if (XLEN == 64) begin
            dec_imm = XLEN'(in_inst[25:20]);
          end else begin
            dec_imm = XLEN'(in_inst[24:20]);
            dec_ill = in_inst[25];
          end
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      7'b0011011: begin
        // Word-sized shifts only have a 5-bit shamt; inst[25] must be zero.
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SH;
            dec_imm = XLEN'(in_inst[24:20]);
            dec_ill = in_inst[25];
          end else begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_inst[31:20]));
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt = FMT_NONE;
      end
      7'b0111011: begin
        dec_ill = (XLEN != 64);
      end
      7'b1110011: begin
`ifdef IMM_ZICSR_EN
        case (funct3)
          3'b000: dec_fmt = FMT_NONE;
          3'b001, 3'b010, 3'b011: begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_inst[31:20]));
          end
          3'b101, 3'b110, 3'b111: begin
            dec_fmt = FMT_Z;
            dec_imm = XLEN'(in_inst[19:15]);
          end
          default: dec_ill = 1'b1;
        endcase
`else
        dec_ill = (funct3 != 3'b000);
`endif
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // Entry A drives the outputs; entry B is the skid slot.
  logic             a_valid, b_valid;
  logic [XLEN-1:0]  a_imm, b_imm;
  logic [2:0]       a_fmt, b_fmt;
  logic             a_ill, b_ill;
  logic [TAG_W-1:0] a_tag, b_tag;

  logic accept, consume;

  // in_ready is only high when B is empty, so an accept never meets a full B.
  assign accept  = in_valid && in_ready;
  assign consume = a_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      in_ready <= 1'b1;
      a_imm    <= '0;
      a_fmt    <= FMT_NONE;
      a_ill    <= 1'b0;
      a_tag    <= '0;
      b_imm    <= '0;
      b_fmt    <= FMT_NONE;
      b_ill    <= 1'b0;
      b_tag    <= '0;
    end else if (flush) begin
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (consume && b_valid) begin
        a_imm    <= b_imm;
        a_fmt    <= b_fmt;
        a_ill    <= b_ill;
        a_tag    <= b_tag;
        b_valid  <= 1'b0;
        in_ready <= 1'b1;
      end else if (accept && (consume || !a_valid)) begin
        a_valid  <= 1'b1;
        a_imm    <= dec_imm;
        a_fmt    <= dec_fmt;
        a_ill    <= dec_ill;
        a_tag    <= in_tag;
      end else if (accept) begin
        b_valid  <= 1'b1;
        b_imm    <= dec_imm;
        b_fmt    <= dec_fmt;
        b_ill    <= dec_ill;
        b_tag    <= in_tag;
        in_ready <= 1'b0;
      end else if (consume) begin
        a_valid  <= 1'b0;
      end
    end
  end

  assign out_valid   = a_valid;
  assign out_imm     = a_imm;
  assign out_fmt     = a_fmt;
  assign out_illegal = a_ill;
  assign out_tag     = a_tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage (XLEN 32 and 64)
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  logic        rdy32, val32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        rdy64, val64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(val32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(val64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction with out_ready high and check both widths next cycle.
  task automatic vec(input string name, input logic [31:0] inst, input logic [31:0] tag,
                     input logic [63:0] e_imm32, input logic [2:0] e_fmt32, input logic e_ill32,
                     input logic [63:0] e_imm64, input logic [2:0] e_fmt64, input logic e_ill64);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_tag    = tag;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, " v32"},   {63'd0, val32}, 64'd1);
    check({name, " imm32"}, {32'd0, imm32}, e_imm32);
    check({name, " fmt32"}, {61'd0, fmt32}, {61'd0, e_fmt32});
    check({name, " ill32"}, {63'd0, ill32}, {63'd0, e_ill32});
    check({name, " tag32"}, {32'd0, tag32}, {32'd0, tag});
    check({name, " v64"},   {63'd0, val64}, 64'd1);
    check({name, " imm64"}, imm64, e_imm64);
    check({name, " fmt64"}, {61'd0, fmt64}, {61'd0, e_fmt64});
    check({name, " ill64"}, {63'd0, ill64}, {63'd0, e_ill64});
  endtask

  logic [31:0] tags [4];
  int idx, emitted, stall_acc;
  logic acc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_tag = 32'd0;
    tags[0] = 32'hA0; tags[1] = 32'hA1; tags[2] = 32'hA2; tags[3] = 32'hA3;
    step(); step();
    rst = 1'b0;
    check("rst out_valid", {63'd0, val32}, 64'd0);
    check("rst in_ready",  {63'd0, rdy32}, 64'd1);
    check("rst imm",       {32'd0, imm32}, 64'd0);
    check("rst fmt",       {61'd0, fmt32}, 64'd0);
    check("rst ill",       {63'd0, ill32}, 64'd0);
    check("rst tag",       {32'd0, tag32}, 64'd0);

    // Back-to-back: each accept coincides with consumption of the previous one.
    vec("addi",  32'hFFF00093, 32'h1001, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    vec("beq",   32'hFE000EE3, 32'h1002, 64'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    vec("lui",   32'h12345037, 32'h1003, 64'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0);
    vec("slli",  32'h02109093, 32'h1004, 64'd1,        3'd6, 1'b1, 64'd33,               3'd6, 1'b0);
    vec("sw",    32'hFE112E23, 32'h1005, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    vec("jal",   32'h0080006F, 32'h1006, 64'd8,        3'd5, 1'b0, 64'd8,                3'd5, 1'b0);
    vec("zero",  32'h00000000, 32'h1007, 64'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
    vec("add",   32'h002081B3, 32'h1008, 64'd0,        3'd0, 1'b0, 64'd0,                3'd0, 1'b0);
    vec("addw",  32'h002081BB, 32'h1009, 64'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b0);
`ifdef IMM_ZICSR_EN
    vec("csrwi", 32'h3002D073, 32'h100A, 64'd5,        3'd7, 1'b0, 64'd5,                3'd7, 1'b0);
`else
    vec("csrwi", 32'h3002D073, 32'h100A, 64'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
`endif

    // Drain, then stall the consumer for three cycles with a continuous producer.
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step();
    check("drain out_valid", {63'd0, val32}, 64'd0);
    idx = 0; emitted = 0; stall_acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (idx < 4);
      in_tag    = tags[idx % 4];
      in_inst   = 32'h00000093 | (32'(idx) << 20);
      if (cyc == 1) check("stall rdy c1", {63'd0, rdy32}, 64'd1);
      if (cyc == 2) check("stall rdy c2", {63'd0, rdy32}, 64'd0);
      if (cyc == 1 || cyc == 2) check("stall hold tag", {32'd0, tag32}, {32'd0, tags[0]});
      acc = in_valid && rdy32;
      if (val32 && out_ready) begin
        if (emitted < 4) begin
          check("order tag", {32'd0, tag32}, {32'd0, tags[emitted]});
          check("order imm", {32'd0, imm32}, 64'(emitted));
        end
        emitted++;
      end
      step();
      if (acc) begin
        idx++;
        if (cyc < 3) stall_acc++;
      end
    end
    check("stall accepts", 64'(stall_acc), 64'd2);
    check("emitted count", 64'(emitted), 64'd4);
    check("total accepts", 64'(idx), 64'd4);

    // Flush with both entries full and an instruction offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'hFFF00093; in_tag = 32'hB0; step();
    in_tag = 32'hB1; step();
    check("fill rdy", {63'd0, rdy32}, 64'd0);
    in_tag = 32'hB2; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", {63'd0, val32}, 64'd0);
    check("flush in_ready",  {63'd0, rdy32}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush no emit", {63'd0, val32}, 64'd0);
    end

    // Flush beats a simultaneous accept into an empty A.
    in_valid = 1'b1; in_tag = 32'hC0; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush drop offer", {63'd0, val32}, 64'd0);

    // Mid-stream reset zeroes data registers.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'hD0; step();
    in_valid = 1'b0;
    check("pre-rst valid", {63'd0, val32}, 64'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    check("mid rst valid", {63'd0, val32}, 64'd0);
    check("mid rst tag",   {32'd0, tag32}, 64'd0);
    check("mid rst imm",   imm64, 64'd0);
    check("mid rst rdy",   {63'd0, rdy64}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
